// File: rtl/vigna_bus_arbiter.sv
// vigna_bus_arbiter: shares one valid/ready memory port between the vigna
// core's instruction and data ports. One master is granted at a time, the
// slave request is registered and held until completion, and an optional
// watchdog aborts hung transfers with an error read word.
module vigna_bus_arbiter #(
    parameter int unsigned ARB_MODE  = 0,
    parameter int unsigned TIMEOUT   = 0,
    parameter logic [31:0] ERR_RDATA = 32'hDEAD0BAD
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        i_valid,
    output logic        i_ready,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,

    input  logic        d_valid,
    output logic        d_ready,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic [31:0] d_rdata,

    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,

    input  logic        err_clear,
    output logic        err_timeout,
    output logic        busy,
    output logic [1:0]  grant
);

    typedef enum logic {
        S_IDLE,
        S_XFER
    } state_t;

    typedef enum logic [1:0] {
        G_NONE = 2'b00,
        G_I    = 2'b01,
        G_D    = 2'b10
    } gnt_t;

    localparam bit          WDOG_EN    = (TIMEOUT != 0);
    localparam logic [15:0] TIMER_LAST = WDOG_EN ? 16'(TIMEOUT - 1) : 16'd0;

    state_t      state;
    gnt_t        gnt;
    gnt_t        last_gnt;
    logic [15:0] timer;

    logic        tmo_hit;
    logic        done;
    logic        pick_d;
    logic        any_req;

    // Completion/abort detection and winner selection for the next grant
    always_comb begin
        tmo_hit = WDOG_EN && (timer == TIMER_LAST);
        done    = (state == S_XFER) && (mem_ready || tmo_hit);
        any_req = i_valid || d_valid;
        if (ARB_MODE == 0) begin
            pick_d = d_valid;
        end else begin
            // A lone requester wins; on a tie the port not served last wins
            pick_d = d_valid && (!i_valid || (last_gnt == G_I));
        end
    end

    // Master-side handshake and status outputs
    always_comb begin
        i_ready = done && (gnt == G_I);
        d_ready = done && (gnt == G_D);
        i_rdata = mem_ready ? mem_rdata : ERR_RDATA;
        d_rdata = mem_ready ? mem_rdata : ERR_RDATA;
        busy    = (state == S_XFER);
        grant   = {gnt == G_D, gnt == G_I};
    end

    // Arbitration FSM with registered slave request
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            gnt       <= G_NONE;
            last_gnt  <= G_I;
            timer     <= '0;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        mem_valid <= 1'b1;
                        timer     <= '0;
                        state     <= S_XFER;
                        if (pick_d) begin
                            gnt       <= G_D;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_wstrb <= d_wstrb;
                        end else begin
                            gnt       <= G_I;
                            mem_addr  <= i_addr;
                            mem_wdata <= '0;
                            mem_wstrb <= '0;
                        end
                    end
                end
                S_XFER: begin
                    if (done) begin
                        mem_valid <= 1'b0;
                        last_gnt  <= gnt;
                        gnt       <= G_NONE;
                        state     <= S_IDLE;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    gnt   <= G_NONE;
                end
            endcase
        end
    end

    // Sticky watchdog flag; a new abort takes precedence over a clear
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_timeout <= 1'b0;
        end else if (done && !mem_ready) begin
            err_timeout <= 1'b1;
        end else if (err_clear) begin
            err_timeout <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vigna_bus_arbiter.sv
// Testbench for vigna_bus_arbiter: two instances (fixed priority with an
// 8-cycle watchdog, round-robin without watchdog) driven by directed steps
// and random traffic, checked against a transaction-level reference model.
module tb_vigna_bus_arbiter;

    localparam logic [31:0] ERR_WORD = 32'hDEAD0BAD;

    logic clk;
    logic resetn;

    logic [1:0]       i_valid, i_ready, d_valid, d_ready;
    logic [1:0][31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
    logic [1:0][3:0]  d_wstrb, mem_wstrb;
    logic [1:0]       mem_valid, mem_ready, err_clear, err_timeout, busy;
    logic [1:0][31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0][1:0]  grant;

    vigna_bus_arbiter #(.ARB_MODE(0), .TIMEOUT(8), .ERR_RDATA(ERR_WORD)) u_fp (
        .clk(clk), .resetn(resetn),
        .i_valid(i_valid[0]), .i_ready(i_ready[0]), .i_addr(i_addr[0]), .i_rdata(i_rdata[0]),
        .d_valid(d_valid[0]), .d_ready(d_ready[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
        .d_wstrb(d_wstrb[0]), .d_rdata(d_rdata[0]),
        .mem_valid(mem_valid[0]), .mem_ready(mem_ready[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_wstrb(mem_wstrb[0]), .mem_rdata(mem_rdata[0]),
        .err_clear(err_clear[0]), .err_timeout(err_timeout[0]), .busy(busy[0]), .grant(grant[0])
    );

    vigna_bus_arbiter #(.ARB_MODE(1), .TIMEOUT(0), .ERR_RDATA(ERR_WORD)) u_rr (
        .clk(clk), .resetn(resetn),
        .i_valid(i_valid[1]), .i_ready(i_ready[1]), .i_addr(i_addr[1]), .i_rdata(i_rdata[1]),
        .d_valid(d_valid[1]), .d_ready(d_ready[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
        .d_wstrb(d_wstrb[1]), .d_rdata(d_rdata[1]),
        .mem_valid(mem_valid[1]), .mem_ready(mem_ready[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_wstrb(mem_wstrb[1]), .mem_rdata(mem_rdata[1]),
        .err_clear(err_clear[1]), .err_timeout(err_timeout[1]), .busy(busy[1]), .grant(grant[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: one in-flight transaction per instance
    int unsigned TO   [2] = '{8, 0};
    int unsigned MODE [2] = '{0, 1};
    bit          m_busy [2];
    bit          m_who_d[2];
    bit          m_last_d[2];
    bit          m_err  [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wdata[2];
    logic [3:0]  m_wstrb[2];
    int          m_age  [2];
    int          lat    [2];
    bit          i_pend [2];
    bit          d_pend [2];
    bit          rereq  [2];
    bit          rnd_lat;
    logic [1:0]  gq0[$];
    logic [1:0]  gq1[$];

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[%0d] got=%h want=%h", tag, k, obs, exp);
        end
    endtask

    function automatic bit m_done(input int k);
        return m_busy[k] && (mem_ready[k] || (TO[k] != 0 && m_age[k] + 1 == int'(TO[k])));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 0; m_who_d[k] = 0; m_last_d[k] = 0; m_err[k] = 0;
            m_addr[k] = '0; m_wdata[k] = '0; m_wstrb[k] = '0; m_age[k] = 0;
            i_pend[k] = 0; d_pend[k] = 0; rereq[k] = 0; lat[k] = -1;
        end
    endtask

    // One clock cycle: drive, check at the falling edge, advance model at the rising edge
    task automatic step();
        for (int k = 0; k < 2; k++) begin
            i_valid[k]   = i_pend[k];
            d_valid[k]   = d_pend[k];
            mem_ready[k] = m_busy[k] && (m_age[k] == lat[k]);
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            logic [1:0]  eg;
            logic [31:0] erd;
            bit          dn;
            dn  = m_done(k);
            eg  = !m_busy[k] ? 2'b00 : (m_who_d[k] ? 2'b10 : 2'b01);
            erd = mem_ready[k] ? mem_rdata[k] : ERR_WORD;
            chk("busy", k, 32'(busy[k]), 32'(m_busy[k]));
            chk("grant", k, 32'(grant[k]), 32'(eg));
            chk("mem_valid", k, 32'(mem_valid[k]), 32'(m_busy[k]));
            chk("mem_addr", k, mem_addr[k], m_addr[k]);
            chk("mem_wdata", k, mem_wdata[k], m_wdata[k]);
            chk("mem_wstrb", k, 32'(mem_wstrb[k]), 32'(m_wstrb[k]));
            chk("i_ready", k, 32'(i_ready[k]), 32'(dn && !m_who_d[k]));
            chk("d_ready", k, 32'(d_ready[k]), 32'(dn && m_who_d[k]));
            chk("err_timeout", k, 32'(err_timeout[k]), 32'(m_err[k]));
            if (dn && m_who_d[k]) chk("d_rdata", k, d_rdata[k], erd);
            if (dn && !m_who_d[k]) chk("i_rdata", k, i_rdata[k], erd);
            if (m_busy[k] && m_age[k] == 0) begin
                if (k == 0) gq0.push_back(grant[k]);
                else        gq1.push_back(grant[k]);
            end
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            bit dn;
            bit wd;
            dn = m_done(k);
            if (dn && !mem_ready[k]) m_err[k] = 1;
            else if (err_clear[k])   m_err[k] = 0;
            if (!m_busy[k]) begin
                if (i_valid[k] || d_valid[k]) begin
                    wd = d_valid[k] && (!i_valid[k] || MODE[k] == 0 || !m_last_d[k]);
                    m_busy[k]  = 1;
                    m_who_d[k] = wd;
                    m_age[k]   = 0;
                    m_addr[k]  = wd ? d_addr[k]  : i_addr[k];
                    m_wdata[k] = wd ? d_wdata[k] : 32'h0;
                    m_wstrb[k] = wd ? d_wstrb[k] : 4'h0;
                    if (rnd_lat) lat[k] = (k == 0) ? int'($urandom_range(0, 10)) : int'($urandom_range(0, 5));
                end
            end else if (dn) begin
                m_busy[k]   = 0;
                m_last_d[k] = m_who_d[k];
                if (m_who_d[k]) d_pend[k] = rereq[k];
                else            i_pend[k] = rereq[k];
            end else begin
                m_age[k]++;
            end
        end
        #1;
    endtask

    initial begin
        resetn    = 1'b0;
        i_valid   = '0; d_valid = '0; mem_ready = '0; err_clear = '0;
        i_addr    = '0; d_addr = '0; d_wdata = '0; d_wstrb = '0; mem_rdata = '0;
        rnd_lat   = 0;
        model_reset();

        // Reset state
        #3;
        for (int k = 0; k < 2; k++) begin
            chk("rst_mem_valid", k, 32'(mem_valid[k]), 32'h0);
            chk("rst_busy", k, 32'(busy[k]), 32'h0);
            chk("rst_grant", k, 32'(grant[k]), 32'h0);
            chk("rst_mem_addr", k, mem_addr[k], 32'h0);
            chk("rst_mem_wdata", k, mem_wdata[k], 32'h0);
            chk("rst_mem_wstrb", k, 32'(mem_wstrb[k]), 32'h0);
            chk("rst_err", k, 32'(err_timeout[k]), 32'h0);
        end
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;

        // Instruction fetch, slave answers 2 cycles after mem_valid
        for (int k = 0; k < 2; k++) begin
            i_pend[k] = 1; i_addr[k] = 32'h100; lat[k] = 2; mem_rdata[k] = 32'h13;
        end
        repeat (5) step();
        for (int k = 0; k < 2; k++) begin
            chk("fetch_addr", k, mem_addr[k], 32'h100);
            chk("fetch_wstrb", k, 32'(mem_wstrb[k]), 32'h0);
        end

        // Simultaneous i and d requests: d first, then i
        gq0.delete(); gq1.delete();
        for (int k = 0; k < 2; k++) begin
            i_pend[k] = 1; i_addr[k] = 32'h200;
            d_pend[k] = 1; d_addr[k] = 32'h2000; d_wdata[k] = 32'hDEADBEEF; d_wstrb[k] = 4'hF;
            lat[k] = 1; mem_rdata[k] = 32'hCAFE0001;
        end
        repeat (8) step();
        chk("tie_first", 0, 32'(gq0.size() > 0 ? gq0[0] : 2'b00), 32'h2);
        chk("tie_second", 0, 32'(gq0.size() > 1 ? gq0[1] : 2'b00), 32'h1);
        chk("tie_first", 1, 32'(gq1.size() > 0 ? gq1[0] : 2'b00), 32'h2);

        // Continuous re-requests with a zero-wait slave
        gq0.delete(); gq1.delete();
        for (int k = 0; k < 2; k++) begin
            rereq[k] = 1; i_pend[k] = 1; d_pend[k] = 1;
            i_addr[k] = 32'h300; d_addr[k] = 32'h4000; d_wstrb[k] = 4'h0; lat[k] = 0;
        end
        repeat (8) step();
        for (int k = 0; k < 2; k++) rereq[k] = 0;
        repeat (6) step();
        for (int j = 0; j < 4; j++) begin
            chk("rr_order", j, 32'(gq1.size() > j ? gq1[j] : 2'b00), (j % 2 == 0) ? 32'h2 : 32'h1);
            chk("fp_order", j, 32'(gq0.size() > j ? gq0[j] : 2'b00), 32'h2);
        end
        repeat (4) step();

        // Watchdog abort on a hung data read
        for (int k = 0; k < 2; k++) begin
            d_pend[k] = 1; d_addr[k] = 32'h5000; d_wstrb[k] = 4'h0; mem_rdata[k] = 32'h0BADF00D;
        end
        lat[0] = -1; lat[1] = 3;
        repeat (10) step();
        chk("tmo_err_set", 0, 32'(err_timeout[0]), 32'h1);
        chk("tmo_err_other", 1, 32'(err_timeout[1]), 32'h0);
        err_clear = 2'b11;
        step();
        err_clear = 2'b00;
        chk("tmo_err_clr", 0, 32'(err_timeout[0]), 32'h0);

        // Slave completes in the last watchdog cycle: normal completion
        for (int k = 0; k < 2; k++) begin
            d_pend[k] = 1; d_addr[k] = 32'h5004; lat[k] = 7; mem_rdata[k] = 32'h12345678;
        end
        repeat (10) step();
        chk("edge_no_err", 0, 32'(err_timeout[0]), 32'h0);

        // Asynchronous reset in the middle of a transfer
        for (int k = 0; k < 2; k++) begin
            d_pend[k] = 1; d_addr[k] = 32'h7000; d_wdata[k] = 32'h55AA55AA; d_wstrb[k] = 4'h3; lat[k] = -1;
        end
        repeat (3) step();
        #2 resetn = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("arst_mem_valid", k, 32'(mem_valid[k]), 32'h0);
            chk("arst_busy", k, 32'(busy[k]), 32'h0);
            chk("arst_grant", k, 32'(grant[k]), 32'h0);
        end
        model_reset();
        for (int k = 0; k < 2; k++) begin
            i_valid[k] = 0; d_valid[k] = 0; mem_ready[k] = 0;
        end
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            i_pend[k] = 1; i_addr[k] = 32'h600; lat[k] = 1; mem_rdata[k] = 32'h00000093;
        end
        repeat (5) step();

        // Random traffic; the granted master's inputs are scrambled to prove they are ignored
        rnd_lat = 1;
        repeat (400) begin
            for (int k = 0; k < 2; k++) begin
                if (!i_pend[k] && ($urandom % 3 == 0)) begin
                    i_pend[k] = 1; i_addr[k] = $urandom;
                end
                if (!d_pend[k] && ($urandom % 3 == 0)) begin
                    d_pend[k] = 1; d_addr[k] = $urandom; d_wdata[k] = $urandom;
                    d_wstrb[k] = ($urandom % 2 == 0) ? 4'h0 : 4'($urandom);
                end
                if (m_busy[k]) begin
                    if (m_who_d[k]) begin
                        d_addr[k] = $urandom; d_wdata[k] = $urandom; d_wstrb[k] = 4'($urandom);
                    end else begin
                        i_addr[k] = $urandom;
                    end
                end
                mem_rdata[k] = $urandom;
                err_clear[k] = ($urandom % 8 == 0);
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
